// File: rtl/match_event_logger.sv
// rtl/match_event_logger.sv - timestamps detector matches into a FWFT FIFO with counters
module match_event_logger #(
  parameter int TS_W  = 16,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     bit_en,
  input  logic                     z,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [TS_W-1:0]          ev_ts,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             match;
  logic             full;
  logic             pop;
  logic             push;

  assign match    = bit_en & z;
  assign full     = (fifo_level == LVL_W'(DEPTH));
  assign ev_valid = (fifo_level != '0);
  assign pop      = ev_valid & ev_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push     = match & (~full | pop);

  // Head is gated so an empty FIFO always presents zero, never stale storage.
  assign ev_ts = ev_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ts;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts         <= '0;
      match_cnt  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      ts         <= '0;
      match_cnt  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (bit_en) begin
        ts <= ts + TS_W'(1);
      end
      if (match && match_cnt != {CNT_W{1'b1}}) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + LVL_W'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LVL_W'(1);
      end
      if (match && !push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_match_event_logger.sv
// tb/tb_match_event_logger.sv - directed self-checking bench for match_event_logger
module tb_match_event_logger;

  localparam int TS_W  = 4;
  localparam int CNT_W = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clear = 1'b0;
  logic             bit_en = 1'b0;
  logic             z = 1'b0;
  logic             ev_ready = 1'b0;
  logic             ev_valid;
  logic [TS_W-1:0]  ev_ts;
  logic [CNT_W-1:0] match_cnt;
  logic [2:0]       fifo_level;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  match_event_logger #(.TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear), .bit_en(bit_en), .z(z),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ts(ev_ts),
    .match_cnt(match_cnt), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; bit_en = 1'b0; z = 1'b0; ev_ready = 1'b0;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ev_valid, ev_ts, match_cnt, fifo_level, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_async got valid=%0b ts=%0d cnt=%0d lvl=%0d ovf=%0b want all 0",
               ev_valid, ev_ts, match_cnt, fifo_level, overflow);
    end
    step(); step();
    reset = 1'b0;
    step();
    checks++;
    if ({ev_valid, ev_ts, match_cnt, fifo_level, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_release got valid=%0b ts=%0d cnt=%0d lvl=%0d ovf=%0b want all 0",
               ev_valid, ev_ts, match_cnt, fifo_level, overflow);
    end
  endtask

  task automatic test_basic();
    ev_ready = 1'b1; bit_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      z = (i == 3 || i == 7);
      step();
      checks++;
      if (ev_valid !== (i == 3 || i == 7)) begin
        errors++;
        $display("FAIL basic_valid bit %0d got %0b want %0b", i, ev_valid, (i == 3 || i == 7));
      end
      if (i == 3 || i == 7) begin
        checks++;
        if (ev_ts !== TS_W'(i)) begin
          errors++;
          $display("FAIL basic_ts bit %0d got %0d want %0d", i, ev_ts, i);
        end
      end
    end
    z = 1'b0; bit_en = 1'b0;
    checks++;
    if (match_cnt !== 8'd2 || overflow !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL basic_final got cnt=%0d ovf=%0b lvl=%0d want 2 0 0", match_cnt, overflow, fifo_level);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    bit_en = 1'b1; z = 1'b1; ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (ev_valid !== 1'b1 || ev_ts !== 4'd0) begin
        errors++;
        $display("FAIL ovf_head_hold bit %0d got valid=%0b ts=%0d want 1 0", i, ev_valid, ev_ts);
      end
    end
    bit_en = 1'b0; z = 1'b0;
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1 || match_cnt !== 8'd6) begin
      errors++;
      $display("FAIL ovf_state got lvl=%0d ovf=%0b cnt=%0d want 4 1 6", fifo_level, overflow, match_cnt);
    end
    ev_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ev_valid !== 1'b1 || ev_ts !== TS_W'(k)) begin
        errors++;
        $display("FAIL ovf_drain %0d got valid=%0b ts=%0d want 1 %0d", k, ev_valid, ev_ts, k);
      end
      step();
    end
    checks++;
    if (ev_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL ovf_empty got valid=%0b lvl=%0d want 0 0", ev_valid, fifo_level);
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_clear();
    bit_en = 1'b1; ev_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      z = (i >= 10);
      step();
    end
    z = 1'b1; ev_ready = 1'b1;
    step();
    z = 1'b0; bit_en = 1'b0;
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pp_state got lvl=%0d ovf=%0b want 4 0", fifo_level, overflow);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ev_valid !== 1'b1 || ev_ts !== TS_W'(11 + k)) begin
        errors++;
        $display("FAIL full_pp_drain %0d got valid=%0b ts=%0d want 1 %0d", k, ev_valid, ev_ts, 11 + k);
      end
      step();
    end
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_pp_empty got valid=%0b want 0", ev_valid);
    end
  endtask

  task automatic test_bit_en_gate();
    // ts is 15 and match_cnt is 5 on entry
    bit_en = 1'b0; z = 1'b1; ev_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < 3; i++) begin
      z = 1'b0; #2 z = 1'b1; #2 z = 1'b0;
      step();
    end
    checks++;
    if (ev_valid !== 1'b0 || match_cnt !== 8'd5) begin
      errors++;
      $display("FAIL gate_ignore got valid=%0b cnt=%0d want 0 5", ev_valid, match_cnt);
    end
    bit_en = 1'b1; z = 1'b0;
    #2 z = 1'b1; #2 z = 1'b0;
    step();
    checks++;
    if (ev_valid !== 1'b0 || match_cnt !== 8'd5) begin
      errors++;
      $display("FAIL gate_glitch got valid=%0b cnt=%0d want 0 5", ev_valid, match_cnt);
    end
    // ts advanced once to 0 during the glitch cycle, so the next match logs 0
    ev_ready = 1'b0; z = 1'b1;
    step();
    bit_en = 1'b0; z = 1'b0;
    checks++;
    if (ev_valid !== 1'b1 || ev_ts !== 4'd0 || match_cnt !== 8'd6) begin
      errors++;
      $display("FAIL gate_ts got valid=%0b ts=%0d cnt=%0d want 1 0 6", ev_valid, ev_ts, match_cnt);
    end
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
  endtask

  task automatic test_saturate_wrap();
    logic [7:0] want_cnt;
    do_clear();
    bit_en = 1'b1; z = 1'b1; ev_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      step();
      want_cnt = (i >= 254) ? 8'd255 : 8'(i + 1);
      checks++;
      if (ev_valid !== 1'b1 || ev_ts !== TS_W'(i % 16) || match_cnt !== want_cnt) begin
        errors++;
        $display("FAIL sat_wrap %0d got valid=%0b ts=%0d cnt=%0d want 1 %0d %0d",
                 i, ev_valid, ev_ts, match_cnt, i % 16, want_cnt);
      end
    end
    bit_en = 1'b0; z = 1'b0;
    step();
    checks++;
    if (ev_valid !== 1'b0 || match_cnt !== 8'd255 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL sat_end got valid=%0b cnt=%0d ovf=%0b want 0 255 0", ev_valid, match_cnt, overflow);
    end
  endtask

  task automatic test_clear_and_reset();
    do_clear();
    bit_en = 1'b1; z = 1'b1; ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    clear = 1'b1; ev_ready = 1'b1;
    step();
    clear = 1'b0; bit_en = 1'b0; z = 1'b0; ev_ready = 1'b0;
    checks++;
    if (fifo_level !== 3'd0 || match_cnt !== 8'd0 || ev_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL clear_state got lvl=%0d cnt=%0d valid=%0b ovf=%0b want 0 0 0 0",
               fifo_level, match_cnt, ev_valid, overflow);
    end
    bit_en = 1'b1; z = 1'b1;
    step(); step();
    bit_en = 1'b0; z = 1'b0;
    checks++;
    if (ev_ts !== 4'd0 || fifo_level !== 3'd2 || match_cnt !== 8'd2) begin
      errors++;
      $display("FAIL clear_ts got ts=%0d lvl=%0d cnt=%0d want 0 2 2", ev_ts, fifo_level, match_cnt);
    end
    ev_ready = 1'b1;
    step();
    checks++;
    if (ev_valid !== 1'b1 || ev_ts !== 4'd1) begin
      errors++;
      $display("FAIL drain_mid got valid=%0b ts=%0d want 1 1", ev_valid, ev_ts);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ev_valid, ev_ts, match_cnt, fifo_level, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_mid got valid=%0b ts=%0d cnt=%0d lvl=%0d ovf=%0b want all 0",
               ev_valid, ev_ts, match_cnt, fifo_level, overflow);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (ev_valid !== 1'b0 || fifo_level !== 3'd0 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_after got valid=%0b lvl=%0d cnt=%0d want 0 0 0", ev_valid, fifo_level, match_cnt);
    end
    ev_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_bit_en_gate();
    test_saturate_wrap();
    test_clear_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_event_logger.md
Name: match_event_logger

Overview:
- Downstream consumer of the serial sequence detector's match output z.
- Each bit cycle it timestamps detector matches, pushes the timestamps into a small first-word-fall-through FIFO, and drains them over a valid/ready port to the host/readout logic.
- It also keeps a saturating total-match counter and a sticky drop flag.

Parameters:
TS_W, 16, width of bit-position timestamp counter and of ev_ts
CNT_W, 8, width of saturating total-match counter
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
clear  in  1  synchronous clear of counters, FIFO and flags
bit_en  in  1  qualifies the current cycle as one serial bit; z is sampled and the timestamp advances only when high
z  in  1  detector match output (combinational Mealy output), sampled at posedge clk
ev_valid  out  1  FIFO head holds an event
ev_ready  in  1  consumer accepts head this cycle
ev_ts  out  TS_W  timestamp of head event
match_cnt  out  CNT_W  total matches seen since reset/clear, saturating
fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
overflow  out  1  sticky: at least one match dropped because the FIFO was full

Behaviour:
- Reset (async, active-high): ts=0, match_cnt=0, FIFO empty (rd/wr pointers=0, level=0), ev_valid=0, ev_ts=0, overflow=0.
- Sampling:
  - z is only looked at on rising clk edges with bit_en=1.
  - z glitches between edges, and z while bit_en=0, are ignored.
  - match = bit_en & z at the edge.
- Timestamp counter ts (TS_W bits): +1 on every bit_en cycle, wraps 2^TS_W-1 -> 0, no flag.
  - The event timestamp is the ts value before the increment, i.e. the index of the bit that produced z.
- match_cnt: +1 per match, saturates at 2^CNT_W-1. It counts every match, including dropped ones.
- Push: on a match, if the FIFO is not full, or is full with a pop in the same cycle, write ts to the tail.
  - Otherwise drop the event and set overflow=1.
  - overflow stays set until clear or reset.
- Pop: ev_valid & ev_ready at the edge removes the head.
- FIFO is first-word-fall-through:
  - A push into an empty FIFO gives ev_valid=1 and ev_ts=pushed value on the cycle after the push edge. Push-to-visible latency is 1 cycle.
  - ev_ts is registered/mux of the head and must hold stable while ev_valid=1 and ev_ready=0.
  - ev_ready while ev_valid=0 has no effect.
- Simultaneous push+pop:
  - Level unchanged.
  - Legal when full.
  - When level=1, the new head appears the next cycle with no bubble.
- Pointers are log2(DEPTH) bits and wrap naturally. fifo_level is tracked separately, or as the wr-rd difference with an extra bit. Full = level==DEPTH, empty = level==0.
- clear (sync, highest priority after reset): next edge sets ts=0, match_cnt=0, FIFO empty, ev_valid=0, overflow=0.
  - A match or pop in the same cycle as clear is discarded, not counted, not logged.
- Reset asserted mid-transfer: all state is lost immediately, ev_valid drops asynchronously, and no partial event is presented after release.
- Outputs change only on clk edges, except under async reset.

Test Plan:
- Reset then 10 bit_en cycles with z=1 only at bits 3 and 7, ev_ready=1 -> two events ev_ts=3 then 7, each ev_valid for one cycle starting 1 cycle after the match edge; match_cnt=2; overflow=0.
- ev_ready=0, matches at bits 0,1,2,3,4,5 (DEPTH=4) -> fifo_level=4, overflow=1, match_cnt=6. Raise ev_ready -> drain exactly 0,1,2,3, then ev_valid=0.
- FIFO full (ts 10..13), match on bit 14 in the same cycle as a pop -> no drop, overflow stays 0, level stays 4, drained order 11,12,13,14.
- bit_en=0 with z=1 for 5 cycles, then z toggled between edges -> no events, ts and match_cnt unchanged.
- CNT_W=8, TS_W=4, 260 consecutive matches with ev_ready=1 -> match_cnt=255 held; ev_ts sequence wraps 15 -> 0.
- Match and clear in the same cycle with 2 queued events; separately, async reset pulse between clock edges mid-drain -> after clear: level=0, match_cnt=0, ev_valid=0 next cycle, overflow=0; after reset: ev_valid=0 immediately and all outputs at reset values.
